// File: rtl/data_mem_responder.sv
// Serialized load/store responder over a DEPTH x 64-bit memory; resp_valid rises LATENCY+1 cycles after acceptance.
// One transaction in flight; resp_ready low stalls in RESP with the response held, and req_ready stays low until the handshake.
module data_mem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;

   logic [63:0] mem [DEPTH];
   logic [60:0] index;
   logic [AW-1:0] mem_idx;
   logic        acc_err;
   logic        access;
   logic        mem_we;

   assign index   = addr_q[63:3];
   assign mem_idx = index[AW-1:0];
   assign acc_err = (addr_q[2:0] != 3'b000) || (index >= 61'(DEPTH));
   assign access  = (state_q == WAIT) && (cnt_q == 4'd0);
   assign mem_we  = access && write_q && !acc_err;

   // Gated by reset so every output reads 0 while reset is held.
   assign req_ready  = (state_q == IDLE) && !reset;
   assign busy       = (state_q != IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 4'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = acc_err;
               resp_rdata_d = (!acc_err && !write_q) ? mem[mem_idx] : 64'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 64'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 64'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Storage is deliberately not reset; a pending store dies with the FSM state.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for most vectors, LATENCY=1 instance for the short-latency case.
module tb_data_mem_responder;

   logic        CLK = 1'b0;
   logic        reset;
   logic        req_valid  [2];
   logic        req_write  [2];
   logic [63:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic        resp_ready [2];
   logic        req_ready  [2];
   logic        resp_valid [2];
   logic        resp_err   [2];
   logic        busy       [2];
   logic [63:0] resp_rdata [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
      .CLK(CLK), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
   );

   data_mem_responder #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (
      .CLK(CLK), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction; inputs are scrambled right after acceptance so only captured values matter.
   task automatic run_txn(input int s, input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input int hold, input int exp_lat, input logic [63:0] exp_rdata, input logic exp_err);
      int lat;
      logic [63:0] rd;
      logic        er;
      check_val("req_ready_idle", 64'(req_ready[s]), 64'd1);
      req_valid[s] = 1'b1;
      req_write[s] = wr;
      req_addr[s]  = addr;
      req_wdata[s] = wdata;
      @(posedge CLK); #1;
      req_valid[s] = 1'b0;
      req_write[s] = ~wr;
      req_addr[s]  = addr + 64'd8;
      req_wdata[s] = ~wdata;
      check_val("busy_after_accept", 64'(busy[s]), 64'd1);
      lat = 1;
      while (!resp_valid[s] && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
      check_val("latency", 64'(lat), 64'(exp_lat));
      rd = resp_rdata[s];
      er = resp_err[s];
      check_val("rdata", rd, exp_rdata);
      check_val("err", 64'(er), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         check_val("hold_vld", 64'(resp_valid[s]), 64'd1);
         check_val("hold_rdata", resp_rdata[s], rd);
         check_val("hold_err", 64'(resp_err[s]), 64'(er));
         check_val("hold_req_ready", 64'(req_ready[s]), 64'd0);
      end
      check_val("resp_req_ready", 64'(req_ready[s]), 64'd0);
      resp_ready[s] = 1'b1;
      @(posedge CLK); #1;
      resp_ready[s] = 1'b0;
      check_val("post_hs_vld", 64'(resp_valid[s]), 64'd0);
      check_val("post_hs_rdata", resp_rdata[s], 64'd0);
      check_val("post_hs_err", 64'(resp_err[s]), 64'd0);
      check_val("post_hs_busy", 64'(busy[s]), 64'd0);
      check_val("post_hs_ready", 64'(req_ready[s]), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_valid[i]  = 1'b0;
         req_write[i]  = 1'b0;
         req_addr[i]   = 64'd0;
         req_wdata[i]  = 64'd0;
         resp_ready[i] = 1'b0;
      end
      reset = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check_val("rst_vld", 64'(resp_valid[0]), 64'd0);
      check_val("rst_err", 64'(resp_err[0]), 64'd0);
      check_val("rst_rdata", resp_rdata[0], 64'd0);
      check_val("rst_busy", 64'(busy[0]), 64'd0);
      reset = 1'b0;
      #1;
      check_val("rst_release_ready", 64'(req_ready[0]), 64'd1);

      // Store then load the same word, back to back.
      run_txn(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, 3, 64'd0, 1'b0);
      run_txn(0, 1'b0, 64'h10, 64'd0, 0, 3, 64'hDEADBEEF_CAFEF00D, 1'b0);

      // Misaligned load, out-of-range store leaving the last word untouched.
      run_txn(0, 1'b0, 64'h13, 64'd0, 0, 3, 64'd0, 1'b1);
      run_txn(0, 1'b1, 64'h1F8, 64'h0123_4567_89AB_CDEF, 0, 3, 64'd0, 1'b0);
      run_txn(0, 1'b1, 64'h200, 64'hFFFF_0000_FFFF_0000, 0, 3, 64'd0, 1'b1);
      run_txn(0, 1'b0, 64'h1F8, 64'd0, 0, 3, 64'h0123_4567_89AB_CDEF, 1'b0);

      // Back-pressure for 5 cycles on a load.
      run_txn(0, 1'b0, 64'h10, 64'd0, 5, 3, 64'hDEADBEEF_CAFEF00D, 1'b0);

      // Inputs changed during WAIT must not redirect the store.
      run_txn(0, 1'b1, 64'h28, 64'h5555_AAAA_5555_AAAA, 0, 3, 64'd0, 1'b0);
      run_txn(0, 1'b1, 64'h20, 64'h1234_5678_9ABC_DEF0, 0, 3, 64'd0, 1'b0);
      run_txn(0, 1'b0, 64'h20, 64'd0, 0, 3, 64'h1234_5678_9ABC_DEF0, 1'b0);
      run_txn(0, 1'b0, 64'h28, 64'd0, 0, 3, 64'h5555_AAAA_5555_AAAA, 1'b0);

      // Reset during WAIT discards the pending store.
      run_txn(0, 1'b1, 64'h8, 64'h1111, 0, 3, 64'd0, 1'b0);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 64'h8;
      req_wdata[0] = 64'h2222;
      @(posedge CLK); #1;
      req_valid[0] = 1'b0;
      check_val("wait_busy", 64'(busy[0]), 64'd1);
      reset = 1'b1;
      #1;
      check_val("mid_rst_busy", 64'(busy[0]), 64'd0);
      check_val("mid_rst_ready", 64'(req_ready[0]), 64'd0);
      check_val("mid_rst_vld", 64'(resp_valid[0]), 64'd0);
      check_val("mid_rst_err", 64'(resp_err[0]), 64'd0);
      check_val("mid_rst_rdata", resp_rdata[0], 64'd0);
      repeat (3) @(posedge CLK);
      #1;
      reset = 1'b0;
      #1;
      run_txn(0, 1'b0, 64'h8, 64'd0, 0, 3, 64'h1111, 1'b0);

      // LATENCY=1 instance: two-cycle latency.
      run_txn(1, 1'b1, 64'h30, 64'hA5A5_5A5A_0F0F_F0F0, 0, 2, 64'd0, 1'b0);
      run_txn(1, 1'b0, 64'h30, 64'd0, 0, 2, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
      run_txn(1, 1'b0, 64'h31, 64'd0, 0, 2, 64'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
